// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl: MMIO window for the 151 core with UART RX/TX FIFOs and cycle/instret counters.
// Define MMIO_IRQ_EN to add the rx_ie control bit and the registered irq output.
module mmio_uart_ctrl #(
  parameter int unsigned RX_DEPTH  = 8,
  parameter int unsigned TX_DEPTH  = 8,
  parameter int unsigned CNT_WIDTH = 32,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic        hit,
  output logic [31:0] rdata,
  input  logic        inst_retire,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
`ifdef MMIO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_PW = RX_AW + 1;
  localparam int unsigned TX_PW = TX_AW + 1;

  localparam logic [5:0] OFF_CTRL = 6'h00;
  localparam logic [5:0] OFF_RXD  = 6'h01;
  localparam logic [5:0] OFF_TXD  = 6'h02;
  localparam logic [5:0] OFF_CYC  = 6'h04;
  localparam logic [5:0] OFF_INST = 6'h05;
  localparam logic [5:0] OFF_CLR  = 6'h06;

  logic [5:0]           word_off;
  logic                 rd_en, wr_en;
  logic                 rd_ctrl, rd_rxd, wr_txd, wr_clr;
  logic [7:0]           rx_mem [RX_DEPTH];
  logic [7:0]           tx_mem [TX_DEPTH];
  logic [RX_PW-1:0]     rx_wptr, rx_rptr;
  logic [TX_PW-1:0]     tx_wptr, tx_rptr;
  logic                 rx_empty, rx_full, rx_push, rx_pop;
  logic                 tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]           rx_head;
  logic                 tx_drop;
  logic                 rx_ie;
  logic [CNT_WIDTH-1:0] cyc_cnt, inst_cnt;
  logic [31:0]          rdata_nxt;
  logic                 unused_bits;

  // Window decode; byte lane bits and upper store data are not used by any register
  assign hit         = (addr[31:8] == MMIO_BASE[31:8]);
  assign word_off    = addr[7:2];
  assign rd_en       = hit & re;
  assign wr_en       = hit & we;
  assign rd_ctrl     = rd_en && (word_off == OFF_CTRL);
  assign rd_rxd      = rd_en && (word_off == OFF_RXD);
  assign wr_txd      = wr_en && (word_off == OFF_TXD);
  assign wr_clr      = wr_en && (word_off == OFF_CLR);
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  // RX FIFO status; a read of an empty FIFO never pops, so a same-cycle push survives
  assign rx_empty      = (rx_wptr == rx_rptr);
  assign rx_full       = (rx_wptr[RX_AW] != rx_rptr[RX_AW]) &&
                         (rx_wptr[RX_AW-1:0] == rx_rptr[RX_AW-1:0]);
  assign uart_rx_ready = ~rx_full;
  assign rx_push       = uart_rx_valid & ~rx_full;
  assign rx_pop        = rd_rxd & ~rx_empty;
  assign rx_head       = rx_mem[rx_rptr[RX_AW-1:0]];

  // TX FIFO status; full is judged before this cycle's pop
  assign tx_empty      = (tx_wptr == tx_rptr);
  assign tx_full       = (tx_wptr[TX_AW] != tx_rptr[TX_AW]) &&
                         (tx_wptr[TX_AW-1:0] == tx_rptr[TX_AW-1:0]);
  assign uart_tx_valid = ~tx_empty;
  assign uart_tx_data  = tx_mem[tx_rptr[TX_AW-1:0]];
  assign tx_push       = wr_txd & ~tx_full;
  assign tx_pop        = uart_tx_valid & uart_tx_ready;

  // FIFO storage (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr[RX_AW-1:0]] <= uart_rx_data;
    if (tx_push) tx_mem[tx_wptr[TX_AW-1:0]] <= wdata[7:0];
  end

  // FIFO pointers, wrapping naturally through the extra MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + RX_PW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + RX_PW'(1);
      if (tx_push) tx_wptr <= tx_wptr + TX_PW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + TX_PW'(1);
    end
  end

  // Sticky drop flag: set on a write to a full TX FIFO, which beats a ctrl-read clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tx_drop <= 1'b0;
    else if (wr_txd & tx_full) tx_drop <= 1'b1;
    else if (rd_ctrl)          tx_drop <= 1'b0;
  end

`ifdef MMIO_IRQ_EN
  logic wr_ctrl;
  assign wr_ctrl = wr_en && (word_off == OFF_CTRL);

  // RX interrupt enable and registered RX-not-empty interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ie <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (wr_ctrl) rx_ie <= wdata[3];
      irq <= rx_ie & ~rx_empty;
    end
  end
`else
  assign rx_ie = 1'b0;
`endif

  // Perf counters; a clear write beats the same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else if (wr_clr) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + CNT_WIDTH'(1);
      if (inst_retire) inst_cnt <= inst_cnt + CNT_WIDTH'(1);
    end
  end

  // Read mux over the pre-update state
  always_comb begin
    rdata_nxt = '0;
    case (word_off)
      OFF_CTRL: rdata_nxt = {28'b0, rx_ie, tx_drop, ~rx_empty, ~tx_full};
      OFF_RXD:  rdata_nxt = rx_empty ? 32'h0 : {24'b0, rx_head};
      OFF_CYC:  rdata_nxt = 32'(cyc_cnt);
      OFF_INST: rdata_nxt = 32'(inst_cnt);
      default:  rdata_nxt = '0;
    endcase
  end

  // Load data register, updated only on a hit read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata <= '0;
    else if (rd_en) rdata <= rdata_nxt;
  end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// tb_mmio_uart_ctrl: directed and randomized checks of mmio_uart_ctrl against a queue-based model.
module tb_mmio_uart_ctrl;
  localparam int unsigned RX_DEPTH  = 8;
  localparam int unsigned TX_DEPTH  = 8;
  localparam int unsigned CNT_WIDTH = 32;
  localparam logic [31:0] BASE      = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic        hit;
  logic [31:0] rdata;
  logic        inst_retire = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_valid = 1'b0;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;
`ifdef MMIO_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [CNT_WIDTH-1:0] m_cyc, m_inst;
  logic [7:0]           tx_seen[$];

  mmio_uart_ctrl #(
    .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH), .CNT_WIDTH(CNT_WIDTH), .MMIO_BASE(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .hit(hit), .rdata(rdata), .inst_retire(inst_retire),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready)
`ifdef MMIO_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  // Counter reference: cycles since reset or since the last clear write
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc  <= '0;
      m_inst <= '0;
    end else if (we && (addr[31:8] == BASE[31:8]) && (addr[7:2] == 6'h06)) begin
      m_cyc  <= '0;
      m_inst <= '0;
    end else begin
      m_cyc <= m_cyc + 1'b1;
      if (inst_retire) m_inst <= m_inst + 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bus helpers: start just after a negedge, end on a negedge
  task automatic bus_write(input logic [7:0] off, input logic [31:0] d);
    addr = BASE | {24'b0, off};
    wdata = d;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] off, output logic [31:0] d);
    addr = BASE | {24'b0, off};
    re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d = rdata;
  endtask

  task automatic drain_tx(input int n);
    tx_seen.delete();
    uart_tx_ready = 1'b1;
    for (int c = 0; c < 4 * TX_DEPTH && tx_seen.size() < n; c++) begin
      if (uart_tx_valid) tx_seen.push_back(uart_tx_data);
      @(negedge clk);
    end
    uart_tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0); end
    n_checks++;
    if (uart_rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b expected 1", uart_rx_ready); end
    n_checks++;
    if (uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", uart_tx_valid); end
`ifdef MMIO_IRQ_EN
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
`endif
    repeat (10) @(negedge clk);
    bus_read(8'h10, got);
    n_checks++;
    if (got !== 32'd10) begin n_fail++; $display("FAIL reset_cycle: got %0d expected %0d", got, 10); end
    bus_read(8'h14, got);
    n_checks++;
    if (got !== 32'd0) begin n_fail++; $display("FAIL reset_instret: got %0d expected 0", got); end
    bus_read(8'h00, got);
    n_checks++;
    if (got !== 32'h1) begin n_fail++; $display("FAIL reset_ctrl: got %h expected %h", got, 32'h1); end
  endtask

  task automatic test_tx_order();
    logic [31:0] got;
    logic [7:0]  exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_write(8'h08, {24'hABCDEF, exp_b[i]});
      bus_read(8'h00, got);
      n_checks++;
      if (got !== 32'h1) begin n_fail++; $display("FAIL tx_order_ctrl[%0d]: got %h expected %h", i, got, 32'h1); end
    end
    drain_tx(3);
    n_checks++;
    if (tx_seen.size() != 3) begin n_fail++; $display("FAIL tx_order_count: got %0d expected 3", tx_seen.size()); end
    for (int i = 0; i < 3 && i < tx_seen.size(); i++) begin
      n_checks++;
      if (tx_seen[i] !== exp_b[i]) begin n_fail++; $display("FAIL tx_order_byte[%0d]: got %h expected %h", i, tx_seen[i], exp_b[i]); end
    end
    n_checks++;
    if (uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_order_empty: got %b expected 0", uart_tx_valid); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] got;
    logic [7:0]  sent[$];
    logic [7:0]  b;
    uart_tx_ready = 1'b0;
    for (int i = 0; i < TX_DEPTH + 1; i++) begin
      b = 8'($urandom);
      sent.push_back(b);
      bus_write(8'h08, {24'h0, b});
    end
    bus_read(8'h00, got);
    n_checks++;
    if (got !== 32'h4) begin n_fail++; $display("FAIL tx_ovf_ctrl1: got %h expected %h", got, 32'h4); end
    bus_read(8'h00, got);
    n_checks++;
    if (got !== 32'h0) begin n_fail++; $display("FAIL tx_ovf_ctrl2: got %h expected %h", got, 32'h0); end
    drain_tx(TX_DEPTH);
    n_checks++;
    if (tx_seen.size() != TX_DEPTH) begin n_fail++; $display("FAIL tx_ovf_count: got %0d expected %0d", tx_seen.size(), TX_DEPTH); end
    for (int i = 0; i < tx_seen.size(); i++) begin
      n_checks++;
      if (tx_seen[i] !== sent[i]) begin n_fail++; $display("FAIL tx_ovf_byte[%0d]: got %h expected %h", i, tx_seen[i], sent[i]); end
    end
    n_checks++;
    if (uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_ovf_empty: got %b expected 0", uart_tx_valid); end
  endtask

  task automatic test_rx_fill();
    logic [31:0] got;
    logic [7:0]  sent[$];
    for (int i = 0; i < RX_DEPTH; i++) begin
      uart_rx_data = 8'($urandom);
      sent.push_back(uart_rx_data);
      uart_rx_valid = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (uart_rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_fill_ready: got %b expected 0", uart_rx_ready); end
    uart_rx_data = 8'hEE;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    bus_read(8'h00, got);
    n_checks++;
    if (got !== 32'h3) begin n_fail++; $display("FAIL rx_fill_ctrl: got %h expected %h", got, 32'h3); end
    for (int i = 0; i < RX_DEPTH; i++) begin
      bus_read(8'h04, got);
      n_checks++;
      if (got !== {24'h0, sent[i]}) begin n_fail++; $display("FAIL rx_fill_byte[%0d]: got %h expected %h", i, got, {24'h0, sent[i]}); end
    end
    bus_read(8'h04, got);
    n_checks++;
    if (got !== 32'h0) begin n_fail++; $display("FAIL rx_empty_read: got %h expected %h", got, 32'h0); end
    bus_read(8'h00, got);
    n_checks++;
    if (got !== 32'h1) begin n_fail++; $display("FAIL rx_empty_ctrl: got %h expected %h", got, 32'h1); end
  endtask

  task automatic test_rx_bypass();
    logic [31:0] got;
    uart_rx_data = 8'h55;
    uart_rx_valid = 1'b1;
    addr = BASE | 32'h04;
    re = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    re = 1'b0;
    n_checks++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL rx_bypass_first: got %h expected %h", rdata, 32'h0); end
    bus_read(8'h04, got);
    n_checks++;
    if (got !== 32'h55) begin n_fail++; $display("FAIL rx_bypass_second: got %h expected %h", got, 32'h55); end
  endtask

  task automatic test_unmapped();
    logic [31:0] got;
    bus_read(8'h0C, got);
    n_checks++;
    if (got !== 32'h0) begin n_fail++; $display("FAIL unmapped_0c: got %h expected 0", got); end
    bus_read(8'h08, got);
    n_checks++;
    if (got !== 32'h0) begin n_fail++; $display("FAIL unmapped_08_read: got %h expected 0", got); end
    uart_rx_data = 8'h3C;
    uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    bus_read(8'h00, got);
    n_checks++;
    if (got !== 32'h3) begin n_fail++; $display("FAIL unmapped_ctrl: got %h expected %h", got, 32'h3); end
    addr = 32'h9000_0004;
    re = 1'b1;
    #1;
    n_checks++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit: got %b expected 0", hit); end
    @(negedge clk);
    re = 1'b0;
    n_checks++;
    if (rdata !== 32'h3) begin n_fail++; $display("FAIL miss_rdata_hold: got %h expected %h", rdata, 32'h3); end
    addr = BASE | 32'hFC;
    #1;
    n_checks++;
    if (hit !== 1'b1) begin n_fail++; $display("FAIL window_hit: got %b expected 1", hit); end
    @(negedge clk);
    bus_read(8'h04, got);
    n_checks++;
    if (got !== 32'h3C) begin n_fail++; $display("FAIL miss_no_pop: got %h expected %h", got, 32'h3C); end
  endtask

  task automatic test_counters();
    logic [31:0] got, exp;
    for (int i = 0; i < 12; i++) begin
      inst_retire = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    inst_retire = 1'b0;
    exp = 32'(m_inst);
    bus_read(8'h14, got);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL instret_count: got %0d expected %0d", got, exp); end
    exp = 32'(m_cyc);
    bus_read(8'h10, got);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL cycle_count: got %0d expected %0d", got, exp); end
    force dut.cyc_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cyc_cnt;
    m_cyc = 32'hFFFF_FFFF;
    bus_read(8'h10, got);
    n_checks++;
    if (got !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cycle_max: got %h expected %h", got, 32'hFFFF_FFFF); end
    bus_read(8'h10, got);
    n_checks++;
    if (got !== 32'h0) begin n_fail++; $display("FAIL cycle_wrap: got %h expected %h", got, 32'h0); end
    inst_retire = 1'b1;
    bus_write(8'h18, $urandom);
    inst_retire = 1'b0;
    bus_read(8'h10, got);
    n_checks++;
    if (got !== 32'h0) begin n_fail++; $display("FAIL clear_cycle: got %h expected 0", got); end
    bus_read(8'h14, got);
    n_checks++;
    if (got !== 32'h0) begin n_fail++; $display("FAIL clear_instret: got %h expected 0", got); end
  endtask

`ifdef MMIO_IRQ_EN
  task automatic test_irq();
    logic [31:0] got;
    bus_write(8'h00, 32'h8);
    bus_read(8'h00, got);
    n_checks++;
    if (got !== 32'h9) begin n_fail++; $display("FAIL irq_ctrl: got %h expected %h", got, 32'h9); end
    uart_rx_data = 8'h77;
    uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b expected 1", irq); end
    bus_read(8'h04, got);
    n_checks++;
    if (got !== 32'h77) begin n_fail++; $display("FAIL irq_byte: got %h expected %h", got, 32'h77); end
    bus_write(8'h00, 32'h0);
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b expected 0", irq); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic        m_drop;
    logic        pend;
    logic [31:0] pend_exp;
    logic        tx_full_pre, rx_full_pre;
    logic [7:0]  b;
    logic [31:0] wd;
    int unsigned op;
    m_drop = 1'b0;
    pend = 1'b0;
    pend_exp = '0;
    for (int i = 0; i < 400; i++) begin
      if (pend) begin
        n_checks++;
        if (rdata !== pend_exp) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, rdata, pend_exp); end
      end
      pend = 1'b0;
      n_checks++;
      if (uart_tx_valid !== (txq.size() != 0)) begin n_fail++; $display("FAIL b2b_tx_valid[%0d]: got %b expected %b", i, uart_tx_valid, txq.size() != 0); end
      if (txq.size() != 0) begin
        n_checks++;
        if (uart_tx_data !== txq[0]) begin n_fail++; $display("FAIL b2b_tx_data[%0d]: got %h expected %h", i, uart_tx_data, txq[0]); end
      end
      n_checks++;
      if (uart_rx_ready !== (rxq.size() != RX_DEPTH)) begin n_fail++; $display("FAIL b2b_rx_ready[%0d]: got %b expected %b", i, uart_rx_ready, rxq.size() != RX_DEPTH); end

      op = $urandom_range(0, 3);
      b = 8'($urandom);
      wd = $urandom;
      uart_tx_ready = 1'($urandom_range(0, 1));
      uart_rx_valid = ($urandom_range(0, 2) == 0);
      uart_rx_data = b;
      we = 1'b0;
      re = 1'b0;
      case (op)
        1: begin addr = BASE | 32'h04; re = 1'b1; end
        2: begin addr = BASE | 32'h08; wdata = wd; we = 1'b1; end
        3: begin addr = BASE; re = 1'b1; end
        default: addr = BASE | 32'h20;
      endcase

      tx_full_pre = (txq.size() == TX_DEPTH);
      rx_full_pre = (rxq.size() == RX_DEPTH);
      if (op == 3) begin
        pend = 1'b1;
        pend_exp = {28'b0, 1'b0, m_drop, rxq.size() != 0, !tx_full_pre};
        m_drop = 1'b0;
      end
      if (op == 1) begin
        pend = 1'b1;
        pend_exp = (rxq.size() != 0) ? {24'h0, rxq.pop_front()} : 32'h0;
      end
      if (uart_tx_ready && txq.size() != 0) void'(txq.pop_front());
      if (op == 2) begin
        if (tx_full_pre) m_drop = 1'b1;
        else txq.push_back(wd[7:0]);
      end
      if (uart_rx_valid && !rx_full_pre) rxq.push_back(b);
      @(negedge clk);
    end
    we = 1'b0;
    re = 1'b0;
    uart_rx_valid = 1'b0;
    uart_tx_ready = 1'b0;
    if (pend) begin
      n_checks++;
      if (rdata !== pend_exp) begin n_fail++; $display("FAIL b2b_rdata_last: got %h expected %h", rdata, pend_exp); end
    end
  endtask

  initial begin
    test_reset();
    test_tx_order();
    test_tx_overflow();
    test_rx_fill();
    test_rx_bypass();
    test_unmapped();
    test_counters();
`ifdef MMIO_IRQ_EN
    test_irq();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
